// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  // Decoded mul/div opcode: bit 1 selects divide, bit 0 selects unsigned.
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath with sign fix-up.
// Sequenced by ex_muldiv: load_i on the accepting edge, calc_i once per step.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             calc_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             cnt_last_o,
  output logic [WIDTH-1:0] res_hi_o,
  output logic [WIDTH-1:0] res_lo_o
);

  logic [1:0]         op_q;
  logic               sa_q, sb_q;     // operand sign flags (signed ops only)
  logic [WIDTH-1:0]   mcand_q;        // |rt|: multiplicand or divisor
  logic [2*WIDTH-1:0] acc_q;          // mul: {partial, multiplier}; div: low half is quotient
  logic [WIDTH:0]     rem_q;          // divide remainder, extra bit exposes the borrow
  logic [CNT_W-1:0]   cnt_q;

  logic               ld_signed;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               is_signed, is_mul;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_shift, div_diff;
  logic [WIDTH-1:0]   quo, rem;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign ld_signed = ~op_i[0];
  assign mag1      = (ld_signed && data1_i[WIDTH-1]) ? -data1_i : data1_i;
  assign mag2      = (ld_signed && data2_i[WIDTH-1]) ? -data2_i : data2_i;

  assign is_signed = ~op_q[0];
  assign is_mul    = ~op_q[1];

  // Multiply step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: shift the next dividend bit into the remainder and try the subtract.
  assign div_shift = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mcand_q};

  // Shift registers, counter and operand capture.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      op_q    <= op_i;
      sa_q    <= ld_signed & data1_i[WIDTH-1];
      sb_q    <= ld_signed & data2_i[WIDTH-1];
      mcand_q <= mag2;
      acc_q   <= {{WIDTH{1'b0}}, mag1};
      rem_q   <= '0;
      cnt_q   <= '0;
    end else if (calc_i) begin
      if (is_mul) begin
        acc_q <= mul_next;
      end else if (div_diff[WIDTH]) begin
        rem_q            <= div_shift;
        acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], 1'b0};
      end else begin
        rem_q            <= div_diff;
        acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], 1'b1};
      end
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_last_o = (cnt_q == CNT_W'(WIDTH-1));

  // Sign fix-up and result selection, consumed by the FIX -> DONE edge.
  // With a zero divisor every subtract succeeds, so the remainder ends up holding
  // |dividend|; re-applying the dividend sign restores the raw rs value for HI.
  always_comb begin
    quo    = acc_q[WIDTH-1:0];
    rem    = rem_q[WIDTH-1:0];
    prod_s = (is_signed && (sa_q ^ sb_q)) ? -acc_q : acc_q;
    quo_s  = (is_signed && (sa_q ^ sb_q)) ? -quo : quo;
    rem_s  = (is_signed && sa_q) ? -rem : rem;
    if (is_mul) begin
      res_hi_o = prod_s[2*WIDTH-1:WIDTH];
      res_lo_o = prod_s[WIDTH-1:0];
    end else begin
      res_hi_o = rem_s;
      res_lo_o = (mcand_q == '0) ? '1 : quo_s;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit owning HI/LO; stalls the front end while busy.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stall_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q;
  logic             load, calc, cnt_last;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign load = (state_q == S_IDLE) && start_i;
  assign calc = (state_q == S_CALC);

  muldiv_datapath #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dp (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .calc_i     (calc),
    .op_i       (op_i),
    .data1_i    (data1_i),
    .data2_i    (data2_i),
    .cnt_last_o (cnt_last),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo)
  );

  // State, HI/LO and the registered completion pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= (state_d == S_DONE);
    end
  end

  // Next state, HI/LO update and stall. start_i in DONE is the same instruction
  // still leaving EX, so DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_CALC;
          stall_o = 1'b1;
        end else begin
          if (hi_we_i) hi_d = data1_i;
          if (lo_we_i) lo_d = data1_i;
        end
      end
      S_CALC: begin
        stall_o = 1'b1;
        if (cnt_last) state_d = S_FIX;
      end
      S_FIX: begin
        stall_o = 1'b1;
        state_d = S_DONE;
        hi_d    = res_hi;
        lo_d    = res_lo;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign done_o = done_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the operand pair and a decoded mul/div opcode from ID/EX. Owns the architectural HI/LO registers.
- Raises a stall to hold IF/ID and ID/EX frozen while an operation is in progress.
- Serves MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI and MFLO read hi_o/lo_o combinationally through the EX result mux.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  EX holds a mul/div instruction (from ID/EX control).
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- data1_i  in  WIDTH  rs operand; post-forwarding value.
- data2_i  in  WIDTH  rt operand; post-forwarding value.
- hi_we_i  in  1  MTHI: write data1_i to HI.
- lo_we_i  in  1  MTLO: write data1_i to LO.
- hi_o  out  WIDTH  HI register.
- lo_o  out  WIDTH  LO register.
- stall_o  out  1  freeze request to the hazard unit; combinational.
- done_o  out  1  one-cycle completion pulse, registered.

Behaviour:
- Reset (rst_i=1 at posedge): state=IDLE, hi_o=0, lo_o=0, done_o=0, counter=0. Reset overrides everything, including mid-operation; the in-flight result is discarded.
- States: IDLE, CALC, FIX, DONE.
- IDLE → CALC when start_i=1. At that edge: latch op; latch |data1_i| and |data2_i| (absolute value only for signed ops); record sign flags; clear the accumulator; counter=0.
- CALC, multiply: one shift-add step per cycle.
- CALC, divide: one restoring shift-subtract step per cycle.
- CALC → FIX when counter=WIDTH-1, i.e. exactly 32 CALC cycles.
- FIX (1 cycle), signed ops only: negate the 64-bit product if the operand signs differ; negate the quotient if the signs differ; give the remainder the dividend's sign.
- FIX → DONE: write HI/LO at this edge. Multiply: HI=product[63:32], LO=product[31:0]. Divide: LO=quotient, HI=remainder.
- DONE → IDLE unconditionally. done_o=1 only in DONE. start_i is ignored in DONE, because it is still the same instruction leaving EX.
- stall_o = (state==IDLE && start_i) || state==CALC || state==FIX. It is 0 in DONE, so the pipeline advances at the DONE edge.
- Latency: start cycle t0 → stall_o high t0..t33 (34 cycles). Result visible on hi_o/lo_o and done_o=1 at t34.
- Back-to-back mul/div: the next instruction reaches EX in IDLE at t35 and starts normally.
- Divide by zero: runs the full timeline; forced result LO=32'hFFFFFFFF, HI=data1_i as latched (raw, unsigned view). No exception is raised.
- Signed overflow, 0x80000000 / -1: falls out naturally; LO=0x80000000, HI=0.
- MTHI/MTLO: act at the posedge only in IDLE with start_i=0. They are ignored in CALC, FIX and DONE.
- start_i with hi_we_i or lo_we_i in the same IDLE cycle: start wins and the write is dropped.
- HI/LO keep their old values throughout CALC and FIX. Reads during an operation return the previous result.
- Arithmetic: magnitudes are WIDTH-bit unsigned. Multiply accumulator is 2*WIDTH bits. Divide remainder register is WIDTH+1 bits so the subtract borrow is visible.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encoding: S_IDLE, S_CALC, S_FIX, S_DONE.
  - the WIDTH default.
- One natural sub-module: muldiv_datapath. It holds the shift registers, the adder/subtractor, the counter and the sign fix-up, driven by state and op from the ex_muldiv FSM.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → stall_o high 34 cycles; done_o at t34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3 × 7 (0xFFFFFFFD, 0x00000007) → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 0x64 / 0x7 → lo=0x0E, hi=0x02.
- DIVU 0x1234 / 0 → lo=0xFFFFFFFF, hi=0x00001234. Then DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTLO 0xA5A5A5A5 in IDLE → lo=0xA5A5A5A5 next cycle. Then start MULTU with hi_we_i=1 in CALC → HI unchanged until done.
- Start MULT, assert rst_i at t10 → next cycle stall_o=0, hi=lo=0, done_o never pulses. Then an immediate new MULTU 6×7 → lo=42 at t34.
